// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   arb_state_e : owner of the outstanding read (2-bit encoding)
//   *_DEF       : default parameter values used by the interface and top
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF        = 32;
  localparam int unsigned DATA_W_DEF        = 32;
  localparam int unsigned LS_STREAK_MAX_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port of the arbiter.
//   slave  : arbiter side (consumes requests and mem_rdata, drives grants/responses/mem strobes)
//   master : environment side (fetch unit, LSU and memory model)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0
//   inc        : increment by one unless already at MAX
//   count      : current value
module mem_arb_sat_cnt #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between
// the instruction-fetch port and the load/store port. LS has priority; after
// LS_STREAK_MAX consecutive LS grants with fetch waiting, fetch is forced.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : if_* fetch port, ls_* load/store port, mem_* memory port
//   perf_if_stall  : fetch wait cycles (saturating), 0 unless MEM_ARB_PERF_EN
//   perf_ls_stall  : LS wait cycles (saturating), 0 unless MEM_ARB_PERF_EN
// Optional feature macro: MEM_ARB_PERF_EN (stall performance counters).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned LS_STREAK_MAX = LS_STREAK_MAX_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] perf_if_stall,
  output logic [CNT_W-1:0] perf_ls_stall
);

  localparam int unsigned STREAK_W = $clog2(LS_STREAK_MAX + 1);

  arb_state_e          state;
  arb_state_e          state_nxt;
  logic                if_gnt;
  logic                ls_gnt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [STREAK_W-1:0] streak;
  logic                streak_full;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;

  assign streak_full = (streak == STREAK_W'(LS_STREAK_MAX));

  // State register: remembers which port owns the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration, memory strobes and next owner. Grants are masked during
  // reset so nothing reaches the memory while rst_n is low.
  always_comb begin
    state_nxt = IDLE;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (bus.ls_req && !(bus.if_req && streak_full)) ls_gnt = 1'b1;
      else if (bus.if_req)                           if_gnt = 1'b1;
    end
    if (if_gnt) begin
      state_nxt = RD_IF;
      mem_addr  = bus.if_addr;
    end else if (ls_gnt) begin
      state_nxt = bus.ls_we ? IDLE : RD_LS;
      mem_addr  = bus.ls_addr;
      mem_we    = bus.ls_we;
      mem_wdata = bus.ls_we ? bus.ls_wdata : '0;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = if_gnt | ls_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Responses: pass mem_rdata through while valid, otherwise show the last value.
  assign bus.if_rvalid = (state == RD_IF);
  assign bus.ls_rvalid = (state == RD_LS);
  assign bus.if_rdata  = (state == RD_IF) ? bus.mem_rdata : if_rdata_q;
  assign bus.ls_rdata  = (state == RD_LS) ? bus.mem_rdata : ls_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (state == RD_IF) if_rdata_q <= bus.mem_rdata;
      if (state == RD_LS) ls_rdata_q <= bus.mem_rdata;
    end
  end

  // LS-while-fetch-waits streak; a fetch grant or an idle fetch port restarts it.
  mem_arb_sat_cnt #(.W(STREAK_W), .MAX(LS_STREAK_MAX)) u_streak (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (if_gnt | ~bus.if_req),
    .inc   (ls_gnt & bus.if_req),
    .count (streak)
  );

`ifdef MEM_ARB_PERF_EN
  mem_arb_sat_cnt #(.W(CNT_W)) u_perf_if (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (bus.if_req & ~if_gnt),
    .count (perf_if_stall)
  );

  mem_arb_sat_cnt #(.W(CNT_W)) u_perf_ls (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (bus.ls_req & ~ls_gnt),
    .count (perf_ls_stall)
  );
`else
  assign perf_if_stall = '0;
  assign perf_ls_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small write-first
// synchronous memory model (64 words, 1-cycle read latency).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] perf_if_stall;
  logic [15:0] perf_ls_stall;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LS_STREAK_MAX(4), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .perf_if_stall (perf_if_stall),
    .perf_ls_stall (perf_ls_stall)
  );

  function automatic logic [31:0] rom(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Memory model: write-first, read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr[5:0]];
    end
  end

  // Requesters must hold req until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.if_req && !bus.if_gnt) |=> bus.if_req)
    else $error("FAIL if_hold: if_req dropped before if_gnt");
  a_ls_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.ls_req && !bus.ls_gnt) |=> bus.ls_req)
    else $error("FAIL ls_hold: ls_req dropped before ls_gnt");

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    #3;
    n_checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.ls_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.ls_rvalid});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ls_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h if_rdata %h ls_rdata %h expected 0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ls_rdata);
    end
    n_checks++;
    if ({perf_if_stall, perf_ls_stall} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_if_stall, perf_ls_stall);
    end
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_if_only;
    for (int n = 0; n < 4; n++) begin
      tick;
      bus.if_req = 1'b1; bus.if_addr = 32'(n);
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_addr} !== {3'b101, 32'(n)}) begin
        n_fail++;
        $display("FAIL if_only_gnt[%0d]: gnt %b%b en %b addr %0d expected 1 0 1 %0d",
                 n, bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_addr, n);
      end
      n_checks++;
      if (bus.if_rvalid !== (n > 0) || (n > 0 && bus.if_rdata !== rom(n - 1))) begin
        n_fail++;
        $display("FAIL if_only_rsp[%0d]: rvalid %b rdata %h expected %b %h",
                 n, bus.if_rvalid, bus.if_rdata, (n > 0), rom(n - 1));
      end
    end
    tick;
    bus.if_req = 1'b0;
    #1;
    n_checks++;
    if (bus.if_gnt !== 1'b0 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== rom(3)) begin
      n_fail++;
      $display("FAIL if_only_last: gnt %b rvalid %b rdata %h expected 0 1 %h",
               bus.if_gnt, bus.if_rvalid, bus.if_rdata, rom(3));
    end
    tick;
    n_checks++;
    if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== rom(3) || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL if_only_hold: rvalid %b rdata %h en %b addr %h expected 0 %h 0 0",
               bus.if_rvalid, bus.if_rdata, bus.mem_en, bus.mem_addr, rom(3));
    end
  endtask

  task automatic test_store_load;
    tick;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'd5; bus.ls_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({bus.ls_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 32'd5, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL store_issue: gnt %b en %b we %b addr %0d wdata %h expected 1 1 1 5 deadbeef",
               bus.ls_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick;
    bus.ls_we = 1'b0; bus.ls_wdata = 32'h1234_5678;
    #1;
    n_checks++;
    if ({bus.ls_gnt, bus.mem_we, bus.mem_wdata, bus.ls_rvalid} !== {2'b10, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_issue: gnt %b we %b wdata %h rvalid %b expected 1 0 0 0",
               bus.ls_gnt, bus.mem_we, bus.mem_wdata, bus.ls_rvalid);
    end
    tick;
    bus.ls_req = 1'b0;
    #1;
    n_checks++;
    if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hDEAD_BEEF || bus.if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_data: rvalid %b rdata %h if_rvalid %b expected 1 deadbeef 0",
               bus.ls_rvalid, bus.ls_rdata, bus.if_rvalid);
    end
    tick;
    n_checks++;
    if (bus.ls_rvalid !== 1'b0 || bus.ls_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_hold: rvalid %b rdata %h expected 0 deadbeef", bus.ls_rvalid, bus.ls_rdata);
    end
  endtask

  task automatic test_back_to_back;
    tick;
    bus.if_req = 1'b1; bus.if_addr = 32'd1;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_if1: gnt %b%b expected 10", bus.if_gnt, bus.ls_gnt);
    end
    tick;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd2;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== 4'b0110 || bus.if_rdata !== rom(1)) begin
      n_fail++;
      $display("FAIL b2b_ls2: gnt %b%b rvalid %b%b rdata %h expected 01 10 %h",
               bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, rom(1));
    end
    tick;
    bus.ls_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd3;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== 4'b1001 || bus.ls_rdata !== rom(2)) begin
      n_fail++;
      $display("FAIL b2b_if3: gnt %b%b rvalid %b%b rdata %h expected 10 01 %h",
               bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.ls_rdata, rom(2));
    end
    tick;
    bus.if_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b10 || bus.if_rdata !== rom(3)) begin
      n_fail++;
      $display("FAIL b2b_tail: rvalid %b%b rdata %h expected 10 %h",
               bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, rom(3));
    end
  endtask

  // Full contention from a fresh reset: LS,LS,LS,LS,IF repeating.
  task automatic test_streak;
    logic [9:0] exp_if;
    int if_a, ls_a, last_ls, last_if;
    logic prev_if, prev_ls;
    exp_if = 10'b10000_10000;
    if_a = 40; ls_a = 20; last_ls = 0; last_if = 0;
    prev_if = 1'b0; prev_ls = 1'b0;
    tick;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      bus.if_req = 1'b1; bus.if_addr = 32'(if_a);
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'(ls_a);
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {exp_if[i], ~exp_if[i]}) begin
        n_fail++;
        $display("FAIL streak_gnt[%0d]: gnt %b%b expected %b%b",
                 i, bus.if_gnt, bus.ls_gnt, exp_if[i], ~exp_if[i]);
      end
      n_checks++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== {prev_if, prev_ls} ||
          (prev_ls && bus.ls_rdata !== rom(last_ls)) || (prev_if && bus.if_rdata !== rom(last_if))) begin
        n_fail++;
        $display("FAIL streak_rsp[%0d]: rvalid %b%b ls_rdata %h if_rdata %h expected %b%b %h %h",
                 i, bus.if_rvalid, bus.ls_rvalid, bus.ls_rdata, bus.if_rdata,
                 prev_if, prev_ls, rom(last_ls), rom(last_if));
      end
      prev_if = exp_if[i];
      prev_ls = ~exp_if[i];
      if (exp_if[i]) begin last_if = if_a; if_a++; end
      else           begin last_ls = ls_a; ls_a++; end
    end
    tick;
    bus.if_req = 1'b0;
    bus.ls_addr = 32'(ls_a);
    #1;
    n_checks++;
    if (bus.ls_gnt !== 1'b1 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== rom(41)) begin
      n_fail++;
      $display("FAIL streak_drain: ls_gnt %b if_rvalid %b if_rdata %h expected 1 1 %h",
               bus.ls_gnt, bus.if_rvalid, bus.if_rdata, rom(41));
    end
    tick;
    bus.ls_req = 1'b0;
    #1;
    n_checks++;
    if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== rom(28)) begin
      n_fail++;
      $display("FAIL streak_last: ls_rvalid %b ls_rdata %h expected 1 %h",
               bus.ls_rvalid, bus.ls_rdata, rom(28));
    end
    n_checks++;
`ifdef MEM_ARB_PERF_EN
    if (perf_if_stall !== 16'd8 || perf_ls_stall !== 16'd2) begin
      n_fail++;
      $display("FAIL perf_stall: if %0d ls %0d expected 8 2", perf_if_stall, perf_ls_stall);
    end
`else
    if (perf_if_stall !== 16'd0 || perf_ls_stall !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_stall: if %0d ls %0d expected 0 0", perf_if_stall, perf_ls_stall);
    end
`endif
  endtask

  task automatic test_reset_mid;
    tick;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd7;
    #1;
    n_checks++;
    if (bus.ls_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt: ls_gnt %b expected 1", bus.ls_gnt);
    end
    tick;
    bus.ls_req = 1'b0;
    #1;
    n_checks++;
    if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== rom(7)) begin
      n_fail++;
      $display("FAIL rstmid_pre: ls_rvalid %b rdata %h expected 1 %h", bus.ls_rvalid, bus.ls_rdata, rom(7));
    end
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd9;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.if_rvalid, bus.ls_rvalid} !== 5'b0 ||
        {bus.mem_addr, bus.ls_rdata, bus.if_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL rstmid_out: ctrl %b addr %h ls_rdata %h if_rdata %h expected 0",
               {bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.if_rvalid, bus.ls_rvalid},
               bus.mem_addr, bus.ls_rdata, bus.if_rdata);
    end
    tick;
    bus.if_req = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++;
      if ({bus.if_rvalid, bus.ls_rvalid, bus.mem_en} !== 3'b0) begin
        n_fail++;
        $display("FAIL rstmid_post[%0d]: rvalid %b%b en %b expected 00 0",
                 i, bus.if_rvalid, bus.ls_rvalid, bus.mem_en);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = rom(i);
    test_reset;
    test_if_only;
    test_store_load;
    test_back_to_back;
    test_streak;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
